serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
- Bit-serial subtractor computing diff = a - b - bin, one bit per clock, LSB first.
- It performs the inverse arithmetic of the team's registered 8-bit adders and uses the same full-cell style, here a full-subtractor cell.
- Intended for area-constrained datapaths where one subtraction per WIDTH+1 cycles is sufficient.
- Operands are captured with a start/busy/done handshake, and the result is held registered until the next completion.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2)

Ports:
clk    input   1      clock, rising edge
rst    input   1      asynchronous reset, active-high
start  input   1      request; sampled only while busy=0
a      input   WIDTH  minuend, captured on accepted start
b      input   WIDTH  subtrahend, captured on accepted start
bin    input   1      borrow-in, captured on accepted start
busy   output  1      high while an operation is in progress
done   output  1      one-cycle pulse: diff/bout/ovf updated this cycle
diff   output  WIDTH  registered difference
bout   output  1      registered borrow-out (1 = unsigned a < b+bin)
ovf    output  1      registered signed overflow

Behaviour:
- Reset (rst=1, asynchronous, applies immediately regardless of clock): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0. Internal operand/shift registers, bit counter and borrow flop are cleared.
- Reset asserted mid-operation aborts the operation. No done pulse is produced and the prior result is lost (outputs read 0).
- FSM states:
  - IDLE. If start=1 at an edge: latch a, b, bin into working registers; borrow flop <= bin; count <= 0; go to RUN; busy=1 from that edge.
  - RUN. Each edge processes bit count (one full-subtractor cell on a[count], b[count], borrow):
    - d = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (br & ~(a_i ^ b_i))
    - d is shifted into the working result from the MSB side. count increments.
  - At the edge processing bit WIDTH-1:
    - diff <= full result
    - bout <= br_next
    - ovf <= (borrow into MSB) ^ br_next
    - done <= 1, busy <= 0, state <= IDLE
- Latency: start sampled at edge T, done high in the cycle after edge T+WIDTH. For WIDTH=8, done is seen 8 edges after the accepting edge.
- done is high for exactly one cycle and deasserts at the next edge unless a new completion occurs there (impossible for WIDTH>=2).
- start while busy=1 is ignored. Operands are not re-sampled, and the in-flight result is unaffected.
- start in the cycle done=1 (state IDLE) is accepted. This allows back-to-back throughput of one result per WIDTH+1 cycles. diff/bout/ovf keep the previous result until the new completion.
- diff/bout/ovf change only at completion or reset. They are not cleared by start.
- a/b/bin may change freely after the accepting edge. Only the captured copies are used.
- Arithmetic is modulo 2^WIDTH:
  - diff = (a - b - bin) mod 2^WIDTH
  - bout = 1 iff a < b + bin (unsigned)
  - ovf = 1 iff the signed two's-complement result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]

Test Plan:
- Reset, then start with a=0x5A, b=0x3C, bin=0 -> busy high for 8 cycles, done pulses once, diff=0x1E, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. Then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0, ovf=0.
- Signed overflow cases:
  - a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF, bin=0 -> diff=0x80, bout=1, ovf=1.
- Start accepted with a=0x55, b=0x11; start pulsed again 3 cycles later with a=0xFF, b=0xFF and operands changed mid-run -> single done, diff=0x44, no second operation.
- Start held high continuously with a=0x20, b=0x05 -> a done pulse every 9 cycles, diff=0x1B each time. Outputs are stable between pulses.
- Start a=0xAA, b=0x01. Assert rst for 1 cycle at bit 4 -> outputs immediately 0, no done. A new start after reset (a=0x03, b=0x05) -> diff=0xFE, bout=1.

Source files
------------

// File: rtl/serial_sub_if.sv
// Handshake and result bundle for the bit-serial subtractor.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  // Subtractor side: consumes operands, produces status and result
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one full-subtractor cell per clock, LSB first.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  serial_sub_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             accept_c;
  logic             last_c;
  logic             d_c;
  logic             br_nxt_c;

  // Full-subtractor cell on the current LSBs of the working operands
  always_comb begin
    d_c      = op_a[0] ^ op_b[0] ^ br;
    br_nxt_c = (~op_a[0] & op_b[0]) | (br & ~(op_a[0] ^ op_b[0]));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept a request when idle, return to idle after the MSB
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept_c  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial datapath and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_c) begin
        op_a   <= bus.a;
        op_b   <= bus.b;
        br     <= bus.bin;
        cnt    <= '0;
        busy_q <= 1'b1;
      end else if (state == RUN) begin
        op_a <= op_a >> 1;
        op_b <= op_b >> 1;
        br   <= br_nxt_c;
        res  <= {d_c, res[WIDTH-1:1]};
        cnt  <= cnt + CW'(1);
        if (last_c) begin
          // br here is the borrow into the MSB cell
          diff_q <= {d_c, res[WIDTH-1:1]};
          bout_q <= br_nxt_c;
          ovf_q  <= br ^ br_nxt_c;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: accepted requests queue arithmetic expectations,
// a monitor pops them on every done pulse.
module tb_serial_sub;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned MASK  = (1 << WIDTH) - 1;
  localparam int          HALF  = 1 << (WIDTH - 1);
  localparam int          FULL  = 1 << WIDTH;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_sub_if #(.WIDTH(WIDTH)) bus ();

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t             sbq[$];
  int               total    = 0;
  int               bad      = 0;
  int               cyc      = 0;
  int               done_cnt = 0;
  logic [WIDTH+1:0] prev     = '0;
  logic             prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic from integer values
  function automatic exp_t model(input int unsigned a, input int unsigned b,
                                 input int unsigned bin, input int c);
    exp_t m;
    int   sa;
    int   sb;
    int   s;
    m.diff = WIDTH'((a - b - bin) & MASK);
    m.bout = (a < b + bin);
    sa     = (a >= HALF) ? int'(a) - FULL : int'(a);
    sb     = (b >= HALF) ? int'(b) - FULL : int'(b);
    s      = sa - sb - int'(bin);
    m.ovf  = (s < -HALF) || (s > HALF - 1);
    m.cyc  = c;
    return m;
  endfunction

  // Request observer: an edge with start=1 and busy=0 is an accepted request
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sbq.delete();
    end else begin
      cyc++;
      if (bus.start && !bus.busy)
        sbq.push_back(model(bus.a, bus.b, bus.bin, cyc));
    end
  end

  // Result monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev      = '0;
      prev_done = 1'b0;
    end else if (bus.done) begin
      done_cnt++;
      chk("done_width", 32'(prev_done), 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("diff", 32'(bus.diff), 32'(e.diff));
        chk("bout", 32'(bus.bout), 32'(e.bout));
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
        chk("latency", 32'(cyc - e.cyc), 32'(WIDTH));
      end
      prev      = {bus.diff, bus.bout, bus.ovf};
      prev_done = 1'b1;
    end else begin
      chk("stable", 32'({bus.diff, bus.bout, bus.ovf}), 32'(prev));
      prev_done = 1'b0;
    end
  end

  task automatic run_op(input int unsigned a, input int unsigned b, input int unsigned bin);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("busy_timeout", 32'd1, 32'd0);
    bus.start = 1'b1;
    bus.a     = WIDTH'(a);
    bus.b     = WIDTH'(b);
    bus.bin   = 1'(bin);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    bus.bin   = 1'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_timeout", 32'(n >= 200), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_diff"}, 32'(bus.diff), 32'd0);
    chk({tag, "_bout"}, 32'(bus.bout), 32'd0);
    chk({tag, "_ovf"},  32'(bus.ovf),  32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int d0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    #1 rst = 1'b0;

    // Basic subtraction and busy duration
    run_op(32'h5A, 32'h3C, 0);
    bc = 0;
    while (bus.busy && bc < 50) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(bc), 32'(WIDTH));
    wait_drain();

    // Unsigned wrap and borrow-in
    run_op(32'h00, 32'h01, 0);
    run_op(32'h10, 32'h0F, 1);
    wait_drain();

    // Signed overflow both directions
    run_op(32'h80, 32'h01, 0);
    run_op(32'h7F, 32'hFF, 0);
    wait_drain();

    // Start while busy is ignored; operands change mid-run
    d0 = done_cnt;
    run_op(32'h55, 32'h11, 0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    wait_drain();
    repeat (20) @(negedge clk);
    chk("ignored_start_dones", 32'(done_cnt - d0), 32'd1);

    // Start held high: back-to-back operations every WIDTH+1 cycles
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h20;
    bus.b     = 8'h05;
    bus.bin   = 1'b0;
    repeat (40) @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    chk("held_start_dones", 32'(done_cnt - d0), 32'd5);

    // Reset in the middle of an operation
    run_op(32'hAA, 32'h01, 0);
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk_outputs_zero("abort");
    @(negedge clk);
    #2 rst = 1'b0;
    run_op(32'h03, 32'h05, 0);
    wait_drain();
    chk("after_abort_dones", 32'(done_cnt - d0), 32'd1);

    // Randomized operations
    repeat (40) begin
      run_op($urandom & MASK, $urandom & MASK, $urandom & 1);
      if (($urandom & 3) == 0) wait_drain();
    end
    wait_drain();

    chk("queue_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
